// File: rtl/dmem_mailbox_pkg.sv
// Shared types and default constants for the data memory / test mailbox block.
package dmem_mailbox_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PASS    = 2'd2,
      ST_TIMEOUT = 2'd3
   } run_state_e;

   localparam logic [2:0]  WIDTH_BYTE       = 3'd0;
   localparam int          WIDTH_WORD_BIT   = 1;

   localparam logic [31:0] DEF_MAILBOX_ADDR = 32'h1001_200c;
   localparam logic [31:0] DEF_PASS_CODE    = 32'h0040_0000;
   localparam logic [31:0] DEF_FAIL_CODE    = 32'h0008_0000;

endpackage

// File: rtl/dmem_byte_ram.sv
// Four-lane byte RAM: lane l holds every byte whose index mod 4 == l, so any
// (possibly misaligned, wrapping) 4-byte access touches each lane exactly once.
module dmem_byte_ram
   import dmem_mailbox_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   localparam int IDX_W = $clog2(DEPTH_BYTES)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [2:0]       width,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   localparam int ROWS = DEPTH_BYTES / 4;

   logic [3:0]      byte_en;
   logic [3:0][7:0] lane_rd;

   assign byte_en = {width[WIDTH_WORD_BIT], width[WIDTH_WORD_BIT],
                     (width != WIDTH_BYTE), 1'b1};

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0]       mem [ROWS];
      logic [1:0]       wk;
      logic [1:0]       rk;
      logic [IDX_W-1:0] widx;
      logic [IDX_W-1:0] ridx;

      // wk/rk: which byte of the access lands in this lane
      assign wk   = 2'(l) - waddr[1:0];
      assign rk   = 2'(l) - raddr[1:0];
      assign widx = waddr + IDX_W'(wk);
      assign ridx = raddr + IDX_W'(rk);

      always_ff @(posedge clk) begin
         if (we && byte_en[wk]) begin
            mem[widx[IDX_W-1:2]] <= wdata[8*wk +: 8];
         end
      end

      assign lane_rd[l] = mem[ridx[IDX_W-1:2]];
   end

   for (genvar k = 0; k < 4; k++) begin : g_rd
      logic [1:0] lane;
      assign lane             = raddr[1:0] + 2'(k);
      assign rdata[8*k +: 8]  = lane_rd[lane];
   end

endmodule

// File: rtl/dmem_mailbox.sv
// Data memory for the core plus a mailbox-driven run-status FSM with pass/fail
// counting, cycle/stall counters and a runaway watchdog.
//
// state   | meaning
// IDLE    | no run started since reset
// RUN     | test running, counters active, mailbox decoded
// PASS    | required pass writes seen
// TIMEOUT | watchdog expired before pass
module dmem_mailbox
   import dmem_mailbox_pkg::*;
#(
   parameter int          DEPTH_BYTES    = 1024,
   parameter logic [31:0] MAILBOX_ADDR   = DEF_MAILBOX_ADDR,
   parameter logic [31:0] PASS_CODE      = DEF_PASS_CODE,
   parameter logic [31:0] FAIL_CODE      = DEF_FAIL_CODE,
   parameter int          PASS_NEEDED    = 2,
   parameter int          TIMEOUT_CYCLES = 3200000,
   parameter int          CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             stall,
   input  logic             c_dmem_store,
   input  logic [2:0]       dmem_store_width,
   input  logic [31:0]      dmem_store_data,
   input  logic [32:0]      dmem_store_addr,
   input  logic [32:0]      dmem_load_addr,
   output logic [31:0]      dmem_load_data,
   output logic [1:0]       state,
   output logic             done,
   output logic [7:0]       fail_cnt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int IDX_W = $clog2(DEPTH_BYTES);
   localparam int PW    = $clog2(PASS_NEEDED + 1);

   run_state_e       st_q, st_d;
   logic [PW-1:0]    pass_q, pass_d, pass_inc;
   logic [7:0]       fail_d;
   logic [CNT_W-1:0] cyc_d, stall_d;
   logic             hit, pass_hit, fail_hit;
   logic             unused_addr_bits;

   // A store racing reset must not land in the RAM.
   dmem_byte_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
      .clk   (clk),
      .we    (c_dmem_store & rstn),
      .width (dmem_store_width),
      .waddr (dmem_store_addr[IDX_W-1:0]),
      .wdata (dmem_store_data),
      .raddr (dmem_load_addr[IDX_W-1:0]),
      .rdata (dmem_load_data)
   );

   assign unused_addr_bits = ^{dmem_store_addr[32], dmem_load_addr[32:IDX_W]};

   assign hit      = c_dmem_store && (dmem_store_addr[31:0] == MAILBOX_ADDR);
   assign pass_hit = hit && (dmem_store_data == PASS_CODE);
   assign fail_hit = hit && (dmem_store_data == FAIL_CODE);
   assign pass_inc = pass_q + PW'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q      <= ST_IDLE;
         pass_q    <= '0;
         fail_cnt  <= '0;
         cycle_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         st_q      <= st_d;
         pass_q    <= pass_d;
         fail_cnt  <= fail_d;
         cycle_cnt <= cyc_d;
         stall_cnt <= stall_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      pass_d  = pass_q;
      fail_d  = fail_cnt;
      cyc_d   = cycle_cnt;
      stall_d = stall_cnt;
      if (start) begin
         st_d    = ST_RUN;
         pass_d  = '0;
         cyc_d   = '0;
         stall_d = '0;
      end else if (st_q == ST_RUN) begin
         cyc_d   = cycle_cnt + CNT_W'(1);
         stall_d = stall_cnt + CNT_W'(stall);
         if (fail_hit && (fail_cnt != 8'hff)) begin
            fail_d = fail_cnt + 8'd1;
         end
         if (pass_hit) begin
            pass_d = pass_inc;
         end
         // Pass completion has priority over the watchdog in the same cycle.
         if (pass_hit && (pass_inc == PW'(PASS_NEEDED))) begin
            st_d = ST_PASS;
         end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            st_d = ST_TIMEOUT;
         end
      end
   end

   assign state = st_q;
   assign done  = (st_q == ST_PASS) || (st_q == ST_TIMEOUT);

endmodule
